reg_fill_scan: RTL and testbench

Sequencer placed directly upstream of the register stack in the register-stack demo top level. On a start pulse it writes all 32 registers with a selectable per-address data pattern (write port), then cycles the read address through 0..31 at a programmable dwell rate so the digital-tube stage shows each register in turn. It replaces the manual address switches and the single-pattern data mux with a self-running fill-then-scan controller.

---
 rtl/reg_fill_scan_if.sv | 22 ++
 rtl/reg_fill_scan.sv | 118 +++++++++++
 tb/tb_reg_fill_scan.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reg_fill_scan_if.sv
// Register-stack side bus of reg_fill_scan: start/pattern request plus the
// write port and shared read address it drives.
interface reg_fill_scan_if;
  logic        Start;
  logic [1:0]  Pattern;
  logic        Write_Reg;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [4:0]  R_Addr;
  logic        Busy;
  logic        Done;

  modport master (
    input  Start, Pattern,
    output Write_Reg, W_Addr, W_Data, R_Addr, Busy, Done
  );

  modport slave (
    output Start, Pattern,
    input  Write_Reg, W_Addr, W_Data, R_Addr, Busy, Done
  );
endinterface

// File: rtl/reg_fill_scan.sv
// Fill-then-scan sequencer for the register stack: writes all registers with a
// patterned value, then steps the read address at a DWELL-cycle rate.
// Optional macro REG_FILL_SKIP_R0_EN starts the fill at address 1 (r0 hardwired).
module reg_fill_scan #(
  parameter int unsigned DWELL = 50000000,
  parameter int unsigned CNT_W = 26
) (
  input  logic           CLK,
  input  logic           Reset,
  reg_fill_scan_if.master rs
);

  typedef enum logic [1:0] {IDLE, FILL, SCAN} state_t;

`ifdef REG_FILL_SKIP_R0_EN
  localparam logic [4:0] FIRST_ADDR = 5'd1;
`else
  localparam logic [4:0] FIRST_ADDR = 5'd0;
`endif
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state, state_nx;
  logic [4:0]       addr_cnt, addr_nx;
  logic [1:0]       pat, pat_nx;
  logic [CNT_W-1:0] dwell, dwell_nx;
  logic             wr_nx, busy_nx, done_nx;
  logic [4:0]       wa_nx, ra_nx;
  logic [31:0]      wd_nx;

  function automatic logic [31:0] base_of(input logic [1:0] p);
    case (p)
      2'b00:   return 32'h5555_5555;
      2'b01:   return 32'h1111_1111;
      2'b10:   return 32'hA1ED_B736;
      default: return 32'h0000_007F;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      pat          <= '0;
      dwell        <= '0;
      rs.Write_Reg <= 1'b0;
      rs.W_Addr    <= '0;
      rs.W_Data    <= '0;
      rs.R_Addr    <= '0;
      rs.Busy      <= 1'b0;
      rs.Done      <= 1'b0;
    end else begin
      state        <= state_nx;
      addr_cnt     <= addr_nx;
      pat          <= pat_nx;
      dwell        <= dwell_nx;
      rs.Write_Reg <= wr_nx;
      rs.W_Addr    <= wa_nx;
      rs.W_Data    <= wd_nx;
      rs.R_Addr    <= ra_nx;
      rs.Busy      <= busy_nx;
      rs.Done      <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_cnt;
    pat_nx   = pat;
    dwell_nx = dwell;
    wr_nx    = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    wa_nx    = rs.W_Addr;
    wd_nx    = rs.W_Data;
    ra_nx    = rs.R_Addr;

    case (state)
      IDLE: begin
        ra_nx = '0;
        if (rs.Start) begin
          state_nx = FILL;
          pat_nx   = rs.Pattern;
          addr_nx  = FIRST_ADDR;
        end
      end
      FILL: begin
        // Address 31 already on the registered write port means the last
        // write is happening this cycle; the next edge enters SCAN with Done.
        if (rs.Write_Reg && rs.W_Addr == 5'd31) begin
          state_nx = SCAN;
          done_nx  = 1'b1;
          ra_nx    = '0;
          dwell_nx = '0;
        end else begin
          wr_nx   = 1'b1;
          busy_nx = 1'b1;
          wa_nx   = addr_cnt;
          wd_nx   = base_of(pat) + {27'b0, addr_cnt};
          addr_nx = addr_cnt + 5'd1;
        end
      end
      SCAN: begin
        if (rs.Start) begin
          state_nx = FILL;
          pat_nx   = rs.Pattern;
          addr_nx  = FIRST_ADDR;
        end else if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          ra_nx    = rs.R_Addr + 5'd1;
        end else begin
          dwell_nx = dwell + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_fill_scan.sv
// Self-checking bench for reg_fill_scan: a cycle-offset model predicts every
// output each cycle, plus literal spot checks at key points.
module tb_reg_fill_scan;
  localparam int DWELL = 3;
`ifdef REG_FILL_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NW = 32 - FIRST;

  logic CLK = 1'b0;
  logic Reset;
  reg_fill_scan_if bus ();

  reg_fill_scan #(.DWELL(DWELL), .CNT_W(4)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .rs   (bus.master)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [1:0] p);
    case (p)
      2'b00:   return 32'h5555_5555;
      2'b01:   return 32'h1111_1111;
      2'b10:   return 32'hA1ED_B736;
      default: return 32'h0000_007F;
    endcase
  endfunction

  // Model: outputs derived from edge offsets since start acceptance / scan entry.
  int          edge_n = 0;
  int          phase = 0;   // 0 idle, 1 fill, 2 scan
  int          k_acc = 0, e_scan = 0, off;
  logic [1:0]  m_pat = 2'b00;
  logic        e_wr = 0, e_busy = 0, e_done = 0;
  logic [4:0]  e_wa = '0, e_ra = '0;
  logic [31:0] e_wd = '0;

  always @(posedge CLK) begin
    logic s, r;
    logic [1:0] p;
    s = bus.Start; r = Reset; p = bus.Pattern;
    edge_n++;
    if (!r) begin
      phase = 0; e_wr = 0; e_busy = 0; e_done = 0;
      e_wa = '0; e_wd = '0; e_ra = '0;
    end else begin
      case (phase)
        0: begin
          e_wr = 0; e_busy = 0; e_done = 0; e_ra = '0;
          if (s) begin phase = 1; k_acc = edge_n; m_pat = p; end
        end
        1: begin
          off = edge_n - k_acc;
          if (off <= NW) begin
            e_wr = 1; e_busy = 1; e_done = 0;
            e_wa = 5'(FIRST + off - 1);
            e_wd = base_of(m_pat) + 32'(e_wa);
          end else begin
            e_wr = 0; e_busy = 0; e_done = 1; e_ra = '0;
            phase = 2; e_scan = edge_n;
          end
        end
        default: begin
          e_wr = 0; e_busy = 0; e_done = 0;
          if (s) begin
            phase = 1; k_acc = edge_n; m_pat = p;
            e_ra = 5'(((edge_n - 1 - e_scan) / DWELL) % 32);
          end else begin
            e_ra = 5'(((edge_n - e_scan) / DWELL) % 32);
          end
        end
      endcase
    end
    #1;
    chk("Write_Reg", 32'(bus.Write_Reg), 32'(e_wr));
    chk("W_Addr",    32'(bus.W_Addr),    32'(e_wa));
    chk("W_Data",    bus.W_Data,         e_wd);
    chk("R_Addr",    32'(bus.R_Addr),    32'(e_ra));
    chk("Busy",      32'(bus.Busy),      32'(e_busy));
    chk("Done",      32'(bus.Done),      32'(e_done));
  end

  task automatic wait_last(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (bus.Write_Reg === 1'b1 && bus.W_Addr === 5'd31) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=no_write_31 expected=write_31", name);
    end
  endtask

  task automatic wait_raddr(input logic [4:0] a);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (bus.R_Addr === a) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL raddr_wait got=%0d expected=%0d", bus.R_Addr, a);
    end
  endtask

  task automatic pulse_start(input logic [1:0] p);
    bus.Pattern = p; bus.Start = 1'b1;
    @(negedge CLK);
    bus.Start = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; bus.Start = 1'b0; bus.Pattern = 2'b00;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    repeat (100) @(negedge CLK);
    chk("idle_wr", 32'(bus.Write_Reg), 32'd0);
    chk("idle_ra", 32'(bus.R_Addr), 32'd0);

    // Fill with pattern 01
    pulse_start(2'b01);
    wait_last("p01");
    chk("p01_last_data", bus.W_Data, 32'h1111_1130);
    @(negedge CLK);
    chk("p01_done", 32'(bus.Done), 32'd1);
    chk("p01_busy", 32'(bus.Busy), 32'd0);
    chk("p01_ra", 32'(bus.R_Addr), 32'd0);

    // Full scan wrap
    repeat (110) @(negedge CLK);

    // Start coinciding with dwell wrap at R_Addr=7
    wait_raddr(5'd6);
    wait_raddr(5'd7);
    repeat (2) @(negedge CLK);
    pulse_start(2'b11);
    chk("wrap_start_ra", 32'(bus.R_Addr), 32'd7);
    chk("wrap_start_wr", 32'(bus.Write_Reg), 32'd0);
    @(negedge CLK);
    chk("p11_first_data", bus.W_Data, 32'h0000_007F + 32'(FIRST));
    repeat (8) @(negedge CLK);
    pulse_start(2'b00);   // ignored while filling
    wait_last("p11");
    chk("p11_last_data", bus.W_Data, 32'h0000_009E);

    repeat (20) @(negedge CLK);
    pulse_start(2'b10);
    wait_last("p10");
    chk("p10_last_data", bus.W_Data, 32'hA1ED_B755);

    // Start held high: back-to-back fills
    repeat (10) @(negedge CLK);
    bus.Pattern = 2'b00; bus.Start = 1'b1;
    repeat (80) @(negedge CLK);
    bus.Start = 1'b0;
    repeat (40) @(negedge CLK);

    // Reset mid-fill at k+15
    pulse_start(2'b01);
    repeat (14) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    chk("rst_wr", 32'(bus.Write_Reg), 32'd0);
    chk("rst_wa", 32'(bus.W_Addr), 32'd0);
    chk("rst_wd", bus.W_Data, 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    pulse_start(2'b01);
    @(negedge CLK);
    chk("restart_wr", 32'(bus.Write_Reg), 32'd1);
    chk("restart_wa", 32'(bus.W_Addr), 32'(FIRST));
    repeat (40) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
